// File: rtl/instr_fetch_if.sv
// instr_fetch_if
//   Bundles the fetch stage's three bus groups:
//     - instruction-memory request/response
//         imem_req, imem_addr, imem_ready, imem_rvalid, imem_rdata
//     - redirect from execute
//         redirect_valid, redirect_pc
//     - decode-side instruction stream
//         instr_valid, instr_out, instr_pc, instr_ready
//   Modports:
//     master : the fetch stage (instr_fetch)
//     slave  : the environment around it (memory, execute, decode)
//
// Handshake semantics (both valid/ready pairs):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   While valid=1 and ready=0, the producer holds valid and its payload unchanged.
//   imem_rvalid has no ready; the fetch stage always accepts a response.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
//   Fetch stage. Owns the PC, issues word requests to instruction memory,
//   buffers returned words in an in-order FIFO and presents {instr, pc} to
//   decode with valid/ready. A redirect from execute reloads the PC, clears
//   the FIFO and arranges for every still-outstanding response to be dropped.
//
// Parameters
//   RESET_PC    PC loaded on reset (word-aligned)
//   FIFO_DEPTH  buffer entries, power of 2 and >= 2; also the outstanding limit
//
// Ports
//   clk               rising-edge clock
//   n_rst             asynchronous active-low reset
//   bus               instr_fetch_if.master (imem, redirect and decode groups)
//   fetch_misaligned  only when FETCH_MISALIGN_CHK_EN is defined: one-cycle
//                     pulse after a redirect whose target had bits[1:0] != 0
//
// Build option
//   FETCH_MISALIGN_CHK_EN  adds fetch_misaligned; without it the low target
//                          bits are silently ignored. Either way the redirect
//                          is applied with pc[1:0] forced to 0.
//
// Handshakes: imem accept = imem_req & imem_ready; decode pop =
//   instr_valid & instr_ready (ignored in a redirect cycle); responses have
//   no back-pressure and arrive in request order.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic n_rst,
  instr_fetch_if.master bus
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic fetch_misaligned
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] fifo_wptr;
  logic [AW-1:0] fifo_rptr;
  logic [AW-1:0] tag_wptr;
  logic [AW-1:0] tag_rptr;

  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic [31:0] fifo_pc    [FIFO_DEPTH];
  // PC of each outstanding request, in issue order; popped on every response
  // (kept or dropped) so it always lines up with the memory's return order.
  logic [31:0] tag_pc     [FIFO_DEPTH];

  logic [CW:0]  occupancy;
  logic         accept;
  logic         resp;
  logic         resp_keep;
  logic         pop;
  logic [31:0]  redirect_target;
  logic         unused_redirect_low;

  assign redirect_target     = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_low = ^bus.redirect_pc[1:0];

  // Counting outstanding requests against the buffer space guarantees every
  // kept response has a free FIFO slot waiting for it.
  assign occupancy    = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign bus.imem_req = n_rst & ~bus.redirect_valid & (occupancy < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_addr = pc;

  assign accept    = bus.imem_req & bus.imem_ready;
  assign resp      = bus.imem_rvalid;
  // A response landing in the redirect cycle belongs to the old stream.
  assign resp_keep = resp & ~bus.redirect_valid & (drop_cnt == '0);
  assign pop       = bus.instr_valid & bus.instr_ready & ~bus.redirect_valid;

  assign bus.instr_valid = (fifo_cnt != '0);
  assign bus.instr_out   = fifo_instr[fifo_rptr];
  assign bus.instr_pc    = fifo_pc[fifo_rptr];

  // PC, counters and pointers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_cnt    <= '0;
      fifo_wptr   <= '0;
      fifo_rptr   <= '0;
      tag_wptr    <= '0;
      tag_rptr    <= '0;
    end else begin
      // No accept can coincide with a redirect (imem_req is low then).
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      if (accept) begin
        tag_wptr <= tag_wptr + AW'(1);
      end
      if (resp) begin
        tag_rptr <= tag_rptr + AW'(1);
      end

      if (bus.redirect_valid) begin
        pc        <= redirect_target;
        // Everything still in flight is stale; the response arriving now is
        // discarded directly, so it is not counted.
        drop_cnt  <= outstanding - CW'(resp);
        fifo_cnt  <= '0;
        fifo_wptr <= fifo_rptr;
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
        end
        if (resp && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (resp_keep) begin
          fifo_wptr <= fifo_wptr + AW'(1);
        end
        if (pop) begin
          fifo_rptr <= fifo_rptr + AW'(1);
        end
        fifo_cnt <= fifo_cnt + CW'(resp_keep) - CW'(pop);
      end
    end
  end

  // Storage. Reset to zero so the decode outputs read 0 out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
        tag_pc[i]     <= '0;
      end
    end else begin
      if (accept) begin
        tag_pc[tag_wptr] <= pc;
      end
      if (resp_keep) begin
        fifo_instr[fifo_wptr] <= bus.imem_rdata;
        fifo_pc[fifo_wptr]    <= tag_pc[tag_rptr];
      end
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_misaligned <= bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
    end
  end
`endif

endmodule
